// File: rtl/tea_key_match_capture_pkg.sv
// Shared constants and state encoding for the TEA key-search match/capture stage.
package tea_key_match_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_SEARCH = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Same constant sizes the TEA decrypt pipeline instance array.
    localparam int unsigned TEA_PIPE_DEPTH = 32;

    localparam logic [63:0] DEF_MAGIC      = 64'h2550_4446_2D31_2E34;
    localparam logic [63:0] DEF_MAGIC_MASK = 64'hFFFF_FFFF_0000_0000;
    localparam logic [31:0] DEF_MAX_CAND   = 32'h7FFF_FFFE;

endpackage

// File: rtl/tea_key_match_capture_sig_compare.sv
// Combinational masked 64-bit signature matcher; only bits set in MASK take part.
module tea_key_match_capture_sig_compare #(
    parameter logic [63:0] SIG  = 64'h0,
    parameter logic [63:0] MASK = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic [63:0] data_i,
    output logic        hit_o
);

    assign hit_o = ((data_i ^ SIG) & MASK) == 64'h0;

endmodule

// File: rtl/tea_key_match_capture.sv
// Flushes stale TEA pipeline contents after start, then scans decrypted blocks for the
// plaintext signature and captures the key/LFSR state of the first hit.
module tea_key_match_capture
    import tea_key_match_capture_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = TEA_PIPE_DEPTH,
    parameter logic [63:0] MAGIC      = DEF_MAGIC,
    parameter logic [63:0] MAGIC_MASK = DEF_MAGIC_MASK,
    parameter logic [31:0] MAX_CAND   = DEF_MAX_CAND
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic [63:0]  data_in,
    input  logic [127:0] key_in,
    input  logic [30:0]  state_in,
    output logic         busy,
    output logic         rdy,
    output logic         found,
    output logic [127:0] found_key,
    output logic [31:0]  found_state,
    output logic [31:0]  cand_count
);

    localparam int FW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(PIPE_DEPTH - 1);

    state_e         state_q;
    logic [FW-1:0]  fill_cnt_q;
    logic [31:0]    cand_q, cand_d;
    logic           busy_q, rdy_q, found_q;
    logic [127:0]   key_q;
    logic [31:0]    fstate_q;
    logic           hit;

    tea_key_match_capture_sig_compare #(
        .SIG  (MAGIC),
        .MASK (MAGIC_MASK)
    ) u_cmp (
        .data_i (data_in),
        .hit_o  (hit)
    );

    // Saturate so a misconfigured MAX_CAND can never wrap the count.
    assign cand_d = (cand_q == MAX_CAND) ? cand_q : cand_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            cand_q     <= '0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            found_q    <= 1'b0;
            key_q      <= '0;
            fstate_q   <= '0;
        end else if (ena) begin
            if (start) begin
                // Start outranks everything, including a hit in the same cycle.
                state_q    <= ST_FILL;
                fill_cnt_q <= '0;
                cand_q     <= '0;
                busy_q     <= 1'b1;
                rdy_q      <= 1'b0;
                found_q    <= 1'b0;
                key_q      <= '0;
                fstate_q   <= '0;
            end else begin
                case (state_q)
                    ST_FILL: begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (fill_cnt_q == FILL_LAST) state_q <= ST_SEARCH;
                    end
                    ST_SEARCH: begin
                        cand_q <= cand_d;
                        if (hit) begin
                            key_q    <= key_in;
                            fstate_q <= {1'b0, state_in};
                            found_q  <= 1'b1;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= ST_DONE;
                        end else if (cand_q == MAX_CAND - 32'd1) begin
                            found_q  <= 1'b0;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign rdy         = rdy_q;
    assign found       = found_q;
    assign found_key   = key_q;
    assign found_state = fstate_q;
    assign cand_count  = cand_q;

endmodule
